acc_alu: RTL and testbench
==========================

# acc_alu

Parametrised, registered accumulator ALU with a valid/ready command interface, status flags, carry-chained arithmetic and multi-cycle shift and multiply operations. It sits between the instruction decoder and the register file. It holds the architectural accumulator and flags across instructions. Single-cycle ops commit in one clock; shifts and multiply iterate in a small FSM and stall the decoder via `o_ready`.

## Interface
- `WIDTH`, 8: datapath and accumulator width, ≥4, power of two.
- `SHW`, `$clog2(WIDTH)`: shift-amount width (derived, not overridden).

Ports:
- `i_clk`  in  1  clock. One clock; all state on rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_valid`  in  1  command valid.
- `o_ready`  out  1  command accepted when `i_valid && o_ready`.
- `i_op`  in  4  opcode.
- `i_reg_file`  in  WIDTH  second operand, sampled at acceptance only.
- `o_accumulator`  out  WIDTH  accumulator register.
- `o_zero`, `o_negative`, `o_carry`, `o_overflow`  out  1 each  flag registers Z/N/C/V.
- `o_busy`  out  1  multi-cycle op in progress.
- `o_done`  out  1  one-cycle pulse when a result is committed.
- `o_err`  out  1  one-cycle pulse with `o_done` for an illegal opcode.

## Operation
- **Opcode map.** Notation: A = accumulator, R = `i_reg_file`, C = carry flag.
  - 0 ADD: A+R
  - 1 SUB: A−R
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT: bitwise ~A
  - 6 LOAD: A=R
  - 7 ADC: A+R+C
  - 8 SBB: A−R−C
  - 9 SHL: logical left by R[SHW-1:0]
  - 10 SHR: logical right by R[SHW-1:0]
  - 11 MUL: low WIDTH bits of A×R, unsigned
  - 12 CLR: A=0
  - 13–15: illegal.
- **Arithmetic width.** Computed in WIDTH+1 bits.
  - ADD/ADC: C = carry-out.
  - SUB/SBB: C = borrow, i.e. 1 when the unsigned true result is below 0.
  - V = two's-complement signed overflow for ADD/ADC/SUB/SBB.
- **Z/N.** Z=(A==0) and N=A[WIDTH-1], updated on every committed legal op.
- **C/V for other ops.**
  - Logic ops, NOT, LOAD, CLR: C=0, V=0.
  - Shifts: C = last bit shifted out; C=0 when the amount is 0; V=0.
  - MUL: C=1 when the high half of the 2·WIDTH product is nonzero; V=0.
- **Illegal opcode.** Accepted; A and all flags unchanged; `o_done` and `o_err` pulse.
- **FSM states.**
  - IDLE: `o_ready`=1, `o_busy`=0.
  - SHIFT: shift counter loaded with the amount; one bit-shift of A per cycle until the counter reaches 0.
  - MUL: internal copies of multiplicand/multiplier plus a 2·WIDTH product register; shift-add one bit per cycle for exactly WIDTH cycles.
  - SHIFT/MUL → IDLE on the last iteration.
- **Shift by 0.** Completes as a single-cycle op (no SHIFT entry).
- **Intermediate values.** During SHIFT, `o_accumulator` shows the partial value. During MUL, A holds its pre-op value until the final write. Consumers sample only on `o_done`.
- **While busy.** `i_valid` is ignored and `i_op`/`i_reg_file` are not sampled; the command is held by the sender.

## Timing
- **Reset values.** A=0, Z=N=C=V=0, `o_ready`=1, `o_busy`=0, `o_done`=0, `o_err`=0, FSM=IDLE, counters=0.
- **Reset mid-operation.** Aborts immediately; no `o_done` is produced.
- **Edge numbering.** Acceptance at edge E0.
- **Single-cycle ops.** A and flags are written at E0. `o_done` is high from E0 to E1. The next command may be accepted at E1, giving back-to-back throughput of 1 per cycle.
- **SHL/SHR by n≥1.**
  - `o_ready` low and `o_busy` high from E0 to En.
  - Shifts occur at E1..En.
  - `o_done` high from En to En+1; `o_ready` is high in the same cycle.
- **MUL.**
  - `o_busy` from E0 to E_WIDTH; iterations at E1..E_WIDTH.
  - A and flags are written at E_WIDTH.
  - `o_done` high from E_WIDTH to E_WIDTH+1.
- **Pulse width.** `o_done` and `o_err` never last more than one cycle per command.

## Test plan
- **Reset.** Assert `i_rst` mid-cycle, asynchronously → all outputs at reset values immediately; `o_ready`=1.
- **ADD overflow.** LOAD 0x7F, then ADD 0x01 → A=0x80, N=1, V=1, C=0, Z=0; `o_done` one cycle after each accept, back-to-back.
- **SUB and carry chain.**
  - A=0x80, SUB 0x81 → A=0xFF, C=1, N=1, V=0.
  - Then ADD 0x01 → A=0x00, Z=1, C=1.
  - Then ADC 0x00 → A=0x01, C=0, Z=0.
- **Shift.** A=0x81, SHL with R=0x03 → `o_ready` low for 3 cycles, A=0x08, C=0; `o_done` 3 cycles after E0. Holding `i_valid` high during busy causes no extra accept. SHR by 0 → single-cycle, A unchanged, C=0.
- **Multiply and reset abort.**
  - A=0x12, MUL 0x10 → after 8 busy cycles A=0x20, C=1, Z=0.
  - Repeat the same MUL and assert `i_rst` at iteration 4 → A=0, no `o_done`.
- **Illegal opcode.** `i_op`=0xE with A=0x5A and C=1 → `o_done`=`o_err`=1 for one cycle; A=0x5A and C=1 unchanged.

Source files
------------

// File: rtl/acc_alu.sv
// Registered accumulator ALU: single-cycle logic/arithmetic, iterative shifts and
// shift-add multiply behind a valid/ready command port, with Z/N/C/V flag registers.
module acc_alu #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_reg_file,
  output logic [WIDTH-1:0] o_accumulator,
  output logic             o_zero,
  output logic             o_negative,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_LOAD = 4'd6;
  localparam logic [3:0] OP_ADC  = 4'd7;
  localparam logic [3:0] OP_SBB  = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_CLR  = 4'd12;
  localparam logic [SHW:0] MUL_ITERS = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     acc_q;
  logic                 z_q, n_q, c_q, v_q;
  logic                 done_q, err_q;
  logic [SHW:0]         cnt_q;
  logic                 dir_right_q;
  logic [WIDTH-1:0]     mcand_q, mplier_q;
  logic [2*WIDTH-1:0]   prod_q;

  logic                 accept;
  logic                 legal, start_shift, start_mul;
  logic [WIDTH-1:0]     res;
  logic                 res_c, res_v;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     sh_val;
  logic                 sh_out;
  logic [2*WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  // Handshake: a command transfers on a rising edge where i_valid && o_ready;
  // o_ready is high only in IDLE, so nothing is sampled while an op iterates.
  assign accept        = i_valid && (state_q == IDLE);
  assign o_ready       = (state_q == IDLE);
  assign o_busy        = (state_q != IDLE);
  assign o_accumulator = acc_q;
  assign o_zero        = z_q;
  assign o_negative    = n_q;
  assign o_carry       = c_q;
  assign o_overflow    = v_q;
  assign o_done        = done_q;
  assign o_err         = err_q;

  always_comb begin
    res         = acc_q;
    res_c       = 1'b0;
    res_v       = 1'b0;
    legal       = 1'b1;
    start_shift = 1'b0;
    start_mul   = 1'b0;
    sum         = '0;
    case (i_op)
      OP_ADD, OP_ADC: begin
        sum   = {1'b0, acc_q} + {1'b0, i_reg_file} + {{WIDTH{1'b0}}, (i_op == OP_ADC) & c_q};
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (acc_q[WIDTH-1] == i_reg_file[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        // Bit WIDTH of the extended difference is the borrow.
        sum   = {1'b0, acc_q} - {1'b0, i_reg_file} - {{WIDTH{1'b0}}, (i_op == OP_SBB) & c_q};
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (acc_q[WIDTH-1] != i_reg_file[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
      end
      OP_AND:  res = acc_q & i_reg_file;
      OP_OR:   res = acc_q | i_reg_file;
      OP_XOR:  res = acc_q ^ i_reg_file;
      OP_NOT:  res = ~acc_q;
      OP_LOAD: res = i_reg_file;
      OP_CLR:  res = '0;
      OP_SHL, OP_SHR: start_shift = (i_reg_file[SHW-1:0] != '0);
      OP_MUL:  start_mul = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    sh_val   = dir_right_q ? (acc_q >> 1) : (acc_q << 1);
    sh_out   = dir_right_q ? acc_q[0] : acc_q[WIDTH-1];
    // Right-shifting accumulation: after WIDTH steps prod holds the full product.
    mul_sum  = {1'b0, prod_q} + (mplier_q[0] ? {1'b0, mcand_q, {WIDTH{1'b0}}} : '0);
    mul_next = mul_sum[2*WIDTH:1];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && start_shift)    state_d = SHIFT;
        else if (accept && start_mul) state_d = MUL;
      end
      SHIFT:   if (cnt_q == 1) state_d = IDLE;
      MUL:     if (cnt_q == 1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q       <= '0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      c_q         <= 1'b0;
      v_q         <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      dir_right_q <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (start_shift) begin
              cnt_q       <= {1'b0, i_reg_file[SHW-1:0]};
              dir_right_q <= (i_op == OP_SHR);
            end else if (start_mul) begin
              mcand_q  <= acc_q;
              mplier_q <= i_reg_file;
              prod_q   <= '0;
              cnt_q    <= MUL_ITERS;
            end else begin
              done_q <= 1'b1;
              err_q  <= ~legal;
              if (legal) begin
                acc_q <= res;
                z_q   <= (res == '0);
                n_q   <= res[WIDTH-1];
                c_q   <= res_c;
                v_q   <= res_v;
              end
            end
          end
        end
        SHIFT: begin
          acc_q <= sh_val;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == 1) begin
            done_q <= 1'b1;
            z_q    <= (sh_val == '0);
            n_q    <= sh_val[WIDTH-1];
            c_q    <= sh_out;
            v_q    <= 1'b0;
          end
        end
        MUL: begin
          prod_q   <= mul_next;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == 1) begin
            done_q <= 1'b1;
            acc_q  <= mul_next[WIDTH-1:0];
            z_q    <= (mul_next[WIDTH-1:0] == '0);
            n_q    <= mul_next[WIDTH-1];
            c_q    <= |mul_next[2*WIDTH-1:WIDTH];
            v_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_alu.sv
// Bench for acc_alu: directed scenarios then random commands, each result checked
// against an arithmetic model of the accumulator and flags.
module tb_acc_alu;

  localparam int W    = 8;
  localparam int FULL = 1 << W;
  localparam int HALF = 1 << (W - 1);
  localparam int MASK = FULL - 1;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_valid = 1'b0;
  logic         o_ready;
  logic [3:0]   i_op = '0;
  logic [W-1:0] i_reg_file = '0;
  logic [W-1:0] o_accumulator;
  logic         o_zero, o_negative, o_carry, o_overflow;
  logic         o_busy, o_done, o_err;

  int n_checks = 0;
  int n_errors = 0;

  // Model state and expected-result queue: {err, v, c, n, z, acc}
  int m_a = 0;
  bit m_z = 0, m_n = 0, m_c = 0, m_v = 0;
  logic [W+4:0] exp_q[$];

  acc_alu #(.WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_reg_file(i_reg_file), .o_accumulator(o_accumulator),
    .o_zero(o_zero), .o_negative(o_negative), .o_carry(o_carry),
    .o_overflow(o_overflow), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_z = 0; m_n = 0; m_c = 0; m_v = 0;
    exp_q.delete();
  endtask

  function automatic int to_signed(input int x);
    return (x >= HALF) ? x - FULL : x;
  endfunction

  task automatic model_apply(input int op, input int r, output int lat);
    int a, res, s, n, cin;
    bit c, v, err;
    longint p;
    logic [W+4:0] e;
    a = m_a; res = a; c = 0; v = 0; err = 0; lat = 1;
    cin = m_c;
    n = r % W;
    case (op)
      0, 7: begin
        if (op == 0) cin = 0;
        res = a + r + cin;
        c = (res > MASK);
        s = to_signed(a) + to_signed(r) + cin;
        v = (s > HALF - 1) || (s < -HALF);
      end
      1, 8: begin
        if (op == 1) cin = 0;
        res = a - r - cin;
        c = (res < 0);
        s = to_signed(a) - to_signed(r) - cin;
        v = (s > HALF - 1) || (s < -HALF);
      end
      2: res = a & r;
      3: res = a | r;
      4: res = a ^ r;
      5: res = ~a;
      6: res = r;
      9: begin
        res = a << n;
        c = (n == 0) ? 1'b0 : bit'((a >> (W - n)) & 1);
        lat = (n == 0) ? 1 : n + 1;
      end
      10: begin
        res = a >> n;
        c = (n == 0) ? 1'b0 : bit'((a >> (n - 1)) & 1);
        lat = (n == 0) ? 1 : n + 1;
      end
      11: begin
        p = longint'(a) * longint'(r);
        res = int'(p % FULL);
        c = (p >= FULL);
        lat = W + 1;
      end
      12: res = 0;
      default: err = 1;
    endcase
    res = res & MASK;
    if (!err) begin
      m_a = res; m_z = (res == 0); m_n = (res >= HALF); m_c = c; m_v = v;
    end
    e = {err, m_v, m_c, m_n, m_z, m_a[W-1:0]};
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge where o_done is seen.
  task automatic do_cmd(input int op, input int r, input bit hold_valid);
    int lat, exp_lat, pre, part;
    logic [W+4:0] e;
    pre = m_a;
    check("ready_idle", o_ready, 1'b1);
    i_valid = 1'b1; i_op = op[3:0]; i_reg_file = r[W-1:0];
    model_apply(op, r, exp_lat);
    @(posedge i_clk);
    @(negedge i_clk);
    if (!hold_valid) i_valid = 1'b0;
    lat = 1;
    while (!o_done && lat < 40) begin
      check("ready_busy", o_ready, 1'b0);
      check("busy", o_busy, 1'b1);
      if (op == 9)       part = (pre << (lat - 1)) & MASK;
      else if (op == 10) part = pre >> (lat - 1);
      else               part = pre;
      check("acc_partial", o_accumulator, part[W-1:0]);
      @(negedge i_clk);
      lat++;
    end
    i_valid = 1'b0;
    if (!o_done) begin
      check("done_timeout", 1'b0, 1'b1);
      void'(exp_q.pop_front());
      return;
    end
    check("latency", lat, exp_lat);
    check("busy_done", o_busy, 1'b0);
    check("ready_done", o_ready, 1'b1);
    if (exp_q.size() == 0) begin
      check("queue_empty", 1'b0, 1'b1);
      return;
    end
    e = exp_q.pop_front();
    check("acc", o_accumulator, e[W-1:0]);
    check("zero", o_zero, e[W]);
    check("negative", o_negative, e[W+1]);
    check("carry", o_carry, e[W+2]);
    check("overflow", o_overflow, e[W+3]);
    check("err", o_err, e[W+4]);
  endtask

  task automatic idle(input int n);
    i_valid = 1'b0;
    repeat (n) begin
      @(negedge i_clk);
      check("done_idle", o_done, 1'b0);
      check("err_idle", o_err, 1'b0);
    end
  endtask

  task automatic check_reset_values();
    check("rst_acc", o_accumulator, '0);
    check("rst_flags", {o_zero, o_negative, o_carry, o_overflow}, 4'b0);
    check("rst_ready", o_ready, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_err", o_err, 1'b0);
  endtask

  // Asserts reset between edges and checks it takes effect without a clock.
  task automatic async_reset();
    @(negedge i_clk);
    #2 i_rst = 1'b1;
    #1 check_reset_values();
    model_reset();
    @(negedge i_clk);
    check("rst_hold_done", o_done, 1'b0);
    i_rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    async_reset();

    // Signed overflow on ADD, back-to-back with LOAD
    do_cmd(6, 'h7F, 0);
    do_cmd(0, 'h01, 0);
    // Borrow and carry chain
    do_cmd(6, 'h80, 0);
    do_cmd(1, 'h81, 0);
    do_cmd(0, 'h01, 0);
    do_cmd(7, 'h00, 0);
    idle(1);
    // Shift with i_valid held through busy, then shift by zero
    do_cmd(6, 'h81, 0);
    do_cmd(9, 'h03, 1);
    do_cmd(10, 'h00, 0);
    idle(1);
    // Multiply
    do_cmd(6, 'h12, 0);
    do_cmd(11, 'h10, 0);
    idle(1);
    // Multiply aborted by reset at iteration 4
    do_cmd(6, 'h12, 0);
    i_valid = 1'b1; i_op = 4'd11; i_reg_file = 8'h10;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    check("mul_busy_mid", o_busy, 1'b1);
    #2 i_rst = 1'b1;
    #1 check_reset_values();
    model_reset();
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    idle(W + 2);
    // Illegal opcode with A=0x5A and C=1
    do_cmd(6, 'hFF, 0);
    do_cmd(0, 'h5B, 0);
    do_cmd(14, 'h33, 0);
    idle(1);

    // Random commands
    for (int i = 0; i < 300; i++) begin
      int op, r;
      op = $urandom_range(0, 15);
      r  = $urandom_range(0, MASK);
      do_cmd(op, r, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      if ($urandom_range(0, 60) == 0) async_reset();
    end
    idle(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
